uart_frame_decoder: RTL and testbench

Byte-stream consumer placed directly downstream of the UART receiver. Accepts received bytes over a valid/ready handshake, hunts for a start-of-frame marker, then parses a length byte, payload and checksum. Payload bytes are forwarded on a registered valid/ready stream, and each frame ends with a one-cycle status pulse (ok or error code). An inter-byte timeout aborts frames stalled mid-stream by a dropped line.

---
 rtl/uart_frame_decoder.sv | 173 +++++++++++++++++
 tb/tb_uart_frame_decoder.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder: hunts for a start-of-frame marker in a received byte stream,
// then parses LEN, LEN payload bytes and a checksum byte. Payload bytes are forwarded
// through a one-entry registered valid/ready stage; each frame ends with a one-cycle
// status pulse carrying an error code. An inter-byte timeout aborts stalled frames.
module uart_frame_decoder #(
    parameter logic [7:0]  SOF     = 8'hA5,
    parameter int unsigned TIMEOUT = 32'd1_000_000
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       status_valid,
    output logic [1:0] status_err
);

    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StLen     = 2'd1;
    localparam logic [1:0] StPayload = 2'd2;
    localparam logic [1:0] StChk     = 2'd3;

    localparam logic [1:0] ErrOk      = 2'd0;
    localparam logic [1:0] ErrChk     = 2'd1;
    localparam logic [1:0] ErrLenZero = 2'd2;
    localparam logic [1:0] ErrTimeout = 2'd3;

    // Last counter value before the abort fires; the counter never passes it,
    // which keeps it saturated well below wrap-around.
    localparam logic [31:0] TmoLast = 32'(TIMEOUT - 1);

    logic [1:0]  state_q, state_d;
    logic [7:0]  count_q, count_d;
    logic [7:0]  sum_q, sum_d;
    logic [31:0] tmo_q, tmo_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;
    logic        out_last_q, out_last_d;
    logic        status_valid_q, status_valid_d;
    logic [1:0]  status_err_q, status_err_d;

    logic        in_ready_w;
    logic        accept;
    logic [7:0]  sum_next;

    // Input readiness depends only on state and the output register occupancy.
    always_comb begin
        in_ready_w = 1'b1;
        if (state_q == StPayload) begin
            in_ready_w = ~out_valid_q | out_ready;
        end
    end

    assign accept   = in_valid & in_ready_w;
    assign sum_next = sum_q + in_data;

    // Frame parser, output register and timeout next-state logic.
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        sum_d          = sum_q;
        tmo_d          = tmo_q;
        out_valid_d    = out_valid_q;
        out_data_d     = out_data_q;
        out_last_d     = out_last_q;
        status_valid_d = 1'b0;
        status_err_d   = status_err_q;

        // A pending payload byte leaves when downstream takes it, even after an abort.
        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end

        unique case (state_q)
            StIdle: begin
                tmo_d = '0;
                if (accept && (in_data == SOF)) begin
                    state_d = StLen;
                end
            end
            StLen: begin
                if (accept) begin
                    count_d = in_data;
                    sum_d   = in_data;
                    if (in_data == 8'h00) begin
                        status_valid_d = 1'b1;
                        status_err_d   = ErrLenZero;
                        state_d        = StIdle;
                    end else begin
                        state_d = StPayload;
                    end
                end
            end
            StPayload: begin
                if (accept) begin
                    out_valid_d = 1'b1;
                    out_data_d  = in_data;
                    out_last_d  = (count_q == 8'd1);
                    sum_d       = sum_next;
                    count_d     = count_q - 8'd1;
                    if (count_q == 8'd1) begin
                        state_d = StChk;
                    end
                end
            end
            StChk: begin
                if (accept) begin
                    sum_d          = sum_next;
                    status_valid_d = 1'b1;
                    status_err_d   = (sum_next == 8'h00) ? ErrOk : ErrChk;
                    state_d        = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Inter-byte timeout; a byte held off by backpressure does not count as idle.
        if (state_q != StIdle) begin
            if (accept) begin
                tmo_d = '0;
            end else if (in_valid && !in_ready_w) begin
                tmo_d = tmo_q;
            end else if (tmo_q >= TmoLast) begin
                tmo_d          = '0;
                status_valid_d = 1'b1;
                status_err_d   = ErrTimeout;
                state_d        = StIdle;
            end else begin
                tmo_d = tmo_q + 32'd1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q        <= StIdle;
            count_q        <= '0;
            sum_q          <= '0;
            tmo_q          <= '0;
            out_valid_q    <= 1'b0;
            out_data_q     <= '0;
            out_last_q     <= 1'b0;
            status_valid_q <= 1'b0;
            status_err_q   <= '0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            sum_q          <= sum_d;
            tmo_q          <= tmo_d;
            out_valid_q    <= out_valid_d;
            out_data_q     <= out_data_d;
            out_last_q     <= out_last_d;
            status_valid_q <= status_valid_d;
            status_err_q   <= status_err_d;
        end
    end

    assign in_ready     = in_ready_w;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign out_last     = out_last_q;
    assign status_valid = status_valid_q;
    assign status_err   = status_err_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Testbench for uart_frame_decoder: directed frames from the test plan plus a randomized
// stream, checked against a frame-level reference parser.
module tb_uart_frame_decoder;

    localparam logic [7:0] SOF = 8'hA5;
    localparam int unsigned TMO = 16;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready = 1'b0;
    logic       status_valid;
    logic [1:0] status_err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int rdy_mode = 1;      // 0 = hold low, 1 = always ready, 2 = random
    bit bp_done;

    logic [8:0] ob_q[$];   // observed {last, data}
    int         oc_q[$];   // cycle of each observed payload byte
    logic [1:0] se_q[$];   // observed status codes
    int         sc_q[$];   // cycle of each status pulse
    logic [8:0] exp_b[$];
    logic [1:0] exp_s[$];
    int         acc_log[$];

    uart_frame_decoder #(.SOF(SOF), .TIMEOUT(TMO)) dut (
        .clk(clk), .nrst(nrst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .status_valid(status_valid), .status_err(status_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 2) out_ready = 1'($urandom_range(0, 1));
        else out_ready = (rdy_mode == 1);
    end

    // Monitor: transfers and pulses observed mid-cycle.
    always @(negedge clk) begin
        if (nrst) begin
            if (out_valid && out_ready) begin
                ob_q.push_back({out_last, out_data});
                oc_q.push_back(cyc);
            end
            if (status_valid) begin
                se_q.push_back(status_err);
                sc_q.push_back(cyc);
            end
        end
    end

    // Reference parser: frames as SOF, LEN, LEN payload bytes, CHK; other bytes ignored.
    task automatic model(input logic [7:0] s[$]);
        int i, len, total;
        i = 0;
        while (i < s.size()) begin
            if (s[i] != SOF) begin
                i++;
                continue;
            end
            i++;
            if (i >= s.size()) break;
            len = int'(s[i]);
            i++;
            if (len == 0) begin
                exp_s.push_back(2'd2);
                continue;
            end
            total = len;
            for (int k = 0; k < len; k++) begin
                exp_b.push_back({(k == len - 1), s[i + k]});
                total += int'(s[i + k]);
            end
            total += int'(s[i + len]);
            exp_s.push_back((total % 256 == 0) ? 2'd0 : 2'd1);
            i += len + 1;
        end
    endtask

    task automatic set_rdy(input int mode);
        rdy_mode = mode;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        bit done;
        n = 0;
        done = 0;
        in_valid = 1'b1;
        in_data = b;
        while (!done) begin
            @(negedge clk);
            if (in_ready === 1'b1) done = 1;
            @(posedge clk);
            #1;
            if (!done) begin
                n++;
                if (n > 500) begin
                    n_checks++;
                    $display("FAIL send_byte: byte %h not accepted within 500 cycles", b);
                    done = 1;
                end
            end
        end
        acc_log.push_back(cyc);
        in_valid = 1'b0;
    endtask

    task automatic send_stream(input logic [7:0] s[$], input int max_gap);
        foreach (s[k]) begin
            send_byte(s[k]);
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while (out_valid === 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            n_checks++;
            $display("FAIL drain: out_valid still high after 300 cycles");
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== 8'h00) $display("FAIL rst_out_data got %h want 00", out_data); else n_pass++;
        n_checks++; if (out_last !== 1'b0) $display("FAIL rst_out_last got %b want 0", out_last); else n_pass++;
        n_checks++; if (status_valid !== 1'b0) $display("FAIL rst_status_valid got %b want 0", status_valid); else n_pass++;
        n_checks++; if (status_err !== 2'd0) $display("FAIL rst_status_err got %0d want 0", status_err); else n_pass++;
        @(posedge clk);
        #1;
        nrst = 1'b1;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", in_ready); else n_pass++;
        @(posedge clk);
        #1;
    endtask

    // Runs stream s with out_ready high and compares all outputs against the model.
    task automatic test_frames(input string name, input logic [7:0] s[$], input bit chk_timing);
        int b0, s0;
        set_rdy(1);
        exp_b.delete();
        exp_s.delete();
        acc_log.delete();
        model(s);
        b0 = ob_q.size();
        s0 = se_q.size();
        send_stream(s, 0);
        drain();
        n_checks++;
        if (ob_q.size() - b0 != exp_b.size())
            $display("FAIL %s byte_count got %0d want %0d", name, ob_q.size() - b0, exp_b.size());
        else n_pass++;
        for (int k = 0; k < exp_b.size() && b0 + k < ob_q.size(); k++) begin
            n_checks++;
            if (ob_q[b0 + k] !== exp_b[k])
                $display("FAIL %s byte[%0d] got %h want %h", name, k, ob_q[b0 + k], exp_b[k]);
            else n_pass++;
        end
        n_checks++;
        if (se_q.size() - s0 != exp_s.size())
            $display("FAIL %s status_count got %0d want %0d", name, se_q.size() - s0, exp_s.size());
        else n_pass++;
        for (int k = 0; k < exp_s.size() && s0 + k < se_q.size(); k++) begin
            n_checks++;
            if (se_q[s0 + k] !== exp_s[k])
                $display("FAIL %s status[%0d] got %0d want %0d", name, k, se_q[s0 + k], exp_s[k]);
            else n_pass++;
        end
        // Single frame with no noise: payload follows at the accept cycle and one per cycle,
        // status appears in the cycle right after the CHK byte is taken.
        if (chk_timing && oc_q.size() >= b0 + 3 && sc_q.size() > s0) begin
            n_checks++;
            if (oc_q[b0] != acc_log[2]) $display("FAIL %s first_out_cycle got %0d want %0d", name, oc_q[b0], acc_log[2]);
            else n_pass++;
            n_checks++;
            if (oc_q[b0 + 2] != oc_q[b0] + 2) $display("FAIL %s out_spacing got %0d want %0d", name, oc_q[b0 + 2] - oc_q[b0], 2);
            else n_pass++;
            n_checks++;
            if (sc_q[s0] != acc_log[acc_log.size() - 1])
                $display("FAIL %s status_cycle got %0d want %0d", name, sc_q[s0], acc_log[acc_log.size() - 1]);
            else n_pass++;
        end
    endtask

    task automatic test_len_zero();
        logic [7:0] s[$];
        int s0;
        s = {SOF, 8'h00};
        s0 = sc_q.size();
        acc_log.delete();
        send_stream(s, 0);
        drain();
        n_checks++;
        if (sc_q.size() <= s0 || sc_q[s0] != acc_log[1] || se_q[s0] !== 2'd2)
            $display("FAIL len_zero_pulse got count %0d want one err-2 pulse at cycle %0d", sc_q.size() - s0, acc_log[1]);
        else n_pass++;
        test_frames("len_zero", {SOF, 8'h00, SOF, 8'h01, 8'h07, 8'hF8}, 0);
    endtask

    task automatic test_timeout();
        int b0, s0, k;
        set_rdy(1);
        b0 = ob_q.size();
        s0 = se_q.size();
        acc_log.delete();
        send_stream({SOF, 8'h02, 8'h11}, 0);
        k = acc_log[2];
        repeat (30) @(posedge clk);
        #1;
        n_checks++;
        if (se_q.size() - s0 != 1) $display("FAIL timeout_count got %0d want 1", se_q.size() - s0);
        else n_pass++;
        if (se_q.size() > s0) begin
            n_checks++;
            if (se_q[s0] !== 2'd3) $display("FAIL timeout_err got %0d want 3", se_q[s0]);
            else n_pass++;
            n_checks++;
            if (sc_q[s0] != k + int'(TMO)) $display("FAIL timeout_cycle got %0d want %0d", sc_q[s0] - k, TMO);
            else n_pass++;
        end
        n_checks++;
        if (ob_q.size() - b0 != 1 || ob_q[b0] !== 9'h011)
            $display("FAIL timeout_payload got %0d bytes want single byte 11 without last", ob_q.size() - b0);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [7:0] s[$];
        int b0, s0, n;
        s = {SOF, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF2};
        exp_b.delete();
        exp_s.delete();
        model(s);
        set_rdy(0);
        b0 = ob_q.size();
        s0 = se_q.size();
        bp_done = 0;
        fork
            begin
                send_stream(s, 0);
                bp_done = 1;
            end
        join_none
        repeat (100) @(posedge clk);
        n_checks++;
        if (se_q.size() != s0) $display("FAIL bp_no_timeout got %0d status pulses want 0", se_q.size() - s0);
        else n_pass++;
        rdy_mode = 1;
        n = 0;
        while (!bp_done && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (!bp_done) begin
            n_checks++;
            $display("FAIL bp_release: stream not finished 200 cycles after release");
        end
        drain();
        n_checks++;
        if (ob_q.size() - b0 != exp_b.size()) $display("FAIL bp_byte_count got %0d want %0d", ob_q.size() - b0, exp_b.size());
        else n_pass++;
        for (int k = 0; k < exp_b.size() && b0 + k < ob_q.size(); k++) begin
            n_checks++;
            if (ob_q[b0 + k] !== exp_b[k]) $display("FAIL bp_byte[%0d] got %h want %h", k, ob_q[b0 + k], exp_b[k]);
            else n_pass++;
        end
        n_checks++;
        if (se_q.size() - s0 != 1 || se_q[s0] !== 2'd0) $display("FAIL bp_status got %0d pulses want one ok", se_q.size() - s0);
        else n_pass++;
    endtask

    task automatic test_reset_mid_frame();
        int s0;
        set_rdy(1);
        s0 = se_q.size();
        send_stream({SOF, 8'h05, 8'h10, 8'h20, 8'h30}, 0);
        nrst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_data, out_last, status_valid, status_err, in_ready} !== 14'h0001)
            $display("FAIL mid_reset_outputs got v%b d%h l%b sv%b se%0d r%b want all reset",
                     out_valid, out_data, out_last, status_valid, status_err, in_ready);
        else n_pass++;
        @(posedge clk);
        #1;
        nrst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (se_q.size() != s0) $display("FAIL mid_reset_status got %0d pulses want 0", se_q.size() - s0);
        else n_pass++;
        test_frames("after_reset", {SOF, 8'h02, 8'h0A, 8'h0B, 8'hE9}, 1);
    endtask

    task automatic test_random();
        logic [7:0] s[$];
        logic [7:0] b, chk;
        int len, sum, b0, s0;
        for (int f = 0; f < 30; f++) begin
            repeat ($urandom_range(0, 2)) begin
                b = 8'($urandom_range(0, 255));
                if (b == SOF) b = 8'h00;
                s.push_back(b);
            end
            s.push_back(SOF);
            len = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 8));
            s.push_back(8'(len));
            if (len > 0) begin
                sum = len;
                for (int k = 0; k < len; k++) begin
                    b = 8'($urandom_range(0, 255));
                    s.push_back(b);
                    sum += int'(b);
                end
                chk = 8'((256 - sum % 256) % 256);
                if ($urandom_range(0, 3) == 0) chk = chk + 8'($urandom_range(1, 255));
                s.push_back(chk);
            end
        end
        exp_b.delete();
        exp_s.delete();
        model(s);
        set_rdy(2);
        b0 = ob_q.size();
        s0 = se_q.size();
        send_stream(s, 3);
        drain();
        n_checks++;
        if (ob_q.size() - b0 != exp_b.size()) $display("FAIL rand_byte_count got %0d want %0d", ob_q.size() - b0, exp_b.size());
        else n_pass++;
        for (int k = 0; k < exp_b.size() && b0 + k < ob_q.size(); k++) begin
            n_checks++;
            if (ob_q[b0 + k] !== exp_b[k]) $display("FAIL rand_byte[%0d] got %h want %h", k, ob_q[b0 + k], exp_b[k]);
            else n_pass++;
        end
        n_checks++;
        if (se_q.size() - s0 != exp_s.size()) $display("FAIL rand_status_count got %0d want %0d", se_q.size() - s0, exp_s.size());
        else n_pass++;
        for (int k = 0; k < exp_s.size() && s0 + k < se_q.size(); k++) begin
            n_checks++;
            if (se_q[s0 + k] !== exp_s[k]) $display("FAIL rand_status[%0d] got %0d want %0d", k, se_q[s0 + k], exp_s[k]);
            else n_pass++;
        end
        set_rdy(1);
    endtask

    initial begin
        test_reset();
        test_frames("basic", {SOF, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97}, 1);
        test_frames("bad_chk", {SOF, 8'h03, 8'h11, 8'h22, 8'h33, 8'h98}, 1);
        test_frames("hunt", {8'h00, 8'hFF, 8'h5A, SOF, 8'h01, SOF, 8'h5A}, 0);
        test_len_zero();
        test_frames("back_to_back", {SOF, 8'h01, 8'h07, 8'hF8, SOF, 8'h02, 8'hA5, 8'h00, 8'h59}, 0);
        test_timeout();
        test_backpressure();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
